nn_training_sequencer: RTL and testbench

//  Hardware sequencer upstream of NeuralNetwork. It replaces the bench-driven XOR training schedule.
//  It drives the RAM read/write-enable phases, reset_value, TestFlag and the x/y sample inputs.
//  It runs EPOCHS passes over the XOR set in the order 00,10,01,11, then a 4-pattern test pass.
//  In the test pass it scores NeuralNetwork's predicted output against x^y.

---
 rtl/nn_training_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_nn_training_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_training_sequencer.sv
// nn_training_sequencer
//   Drives the XOR training schedule for NeuralNetwork. Each run loads the
//   initial parameters, trains for EPOCHS passes over the samples 00,10,01,11,
//   then presents all four patterns with TestFlag high and scores the
//   predicted class against x^y.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start               1-cycle run request, ignored unless idle
//   predicted           NeuralNetwork classification output
//   x_input, y_input    sample presented to the network
//   write_en, read_en   NeuronRAM write / read phases
//   write_en1, read_en1 FP parameters -> RAM1, RAM1 -> BP network
//   write_en2, read_en2 BP parameters -> RAM2, RAM2 -> NeuronRAM
//   reset_value         1 = NeuronRAM loads initial parameters
//   TestFlag            inference-only test pass
//   busy, done          run in progress / 1-cycle end-of-run pulse
//   epoch_count         completed training epochs
//   test_correct        correctly classified test patterns (0..4)
//   test_pass           all four test patterns correct
module nn_training_sequencer #(
  parameter int unsigned PHASE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 12,
  parameter int unsigned EPOCHS     = 10000,
  parameter int unsigned EPOCH_W    = 14,
  parameter int unsigned TEST_HOLD  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         predicted,
  output logic               x_input,
  output logic               y_input,
  output logic               write_en,
  output logic               read_en,
  output logic               write_en1,
  output logic               read_en1,
  output logic               write_en2,
  output logic               read_en2,
  output logic               reset_value,
  output logic               TestFlag,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [2:0]         test_correct,
  output logic               test_pass
);

  typedef enum logic [3:0] {
    StIdle, StInitWrn, StInitRdn, StSettle, StWr1, StRd1, StWr2, StRd2,
    StWrn, StRdn, StTest, StDone
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  pat_q;
  logic [15:0] hold_len;
  logic        hold_last;
  logic        hit;
  logic        last_epoch;
  logic [1:0]  pat_nxt;

  always_comb begin
    hold_len = 16'(PHASE_CYC);
    if (state_q == StSettle) begin
      hold_len = 16'(SETTLE_CYC);
    end else if (state_q == StTest) begin
      hold_len = 16'(TEST_HOLD);
    end
  end

  assign hold_last  = (cnt_q == hold_len - 16'd1);
  assign hit        = (predicted == {1'b0, x_input ^ y_input});
  assign pat_nxt    = pat_q + 2'd1;
  assign last_epoch = ((epoch_count + EPOCH_W'(1)) == EPOCH_W'(EPOCHS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pat_q        <= '0;
      x_input      <= 1'b0;
      y_input      <= 1'b0;
      write_en     <= 1'b0;
      read_en      <= 1'b0;
      write_en1    <= 1'b0;
      read_en1     <= 1'b0;
      write_en2    <= 1'b0;
      read_en2     <= 1'b0;
      reset_value  <= 1'b1;
      TestFlag     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      epoch_count  <= '0;
      test_correct <= '0;
      test_pass    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StInitWrn;
            cnt_q        <= '0;
            pat_q        <= '0;
            busy         <= 1'b1;
            reset_value  <= 1'b1;
            write_en     <= 1'b1;
            epoch_count  <= '0;
            test_correct <= '0;
            test_pass    <= 1'b0;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          if (!hold_last) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= '0;
            case (state_q)
              StInitWrn: begin
                write_en <= 1'b0;
                read_en  <= 1'b1;
                state_q  <= StInitRdn;
              end
              StInitRdn: begin
                read_en <= 1'b0;
                x_input <= 1'b0;
                y_input <= 1'b0;
                if (EPOCHS == 0) begin
                  TestFlag <= 1'b1;
                  state_q  <= StTest;
                end else begin
                  state_q <= StSettle;
                end
              end
              StSettle: begin
                write_en1 <= 1'b1;
                state_q   <= StWr1;
              end
              StWr1: begin
                write_en1 <= 1'b0;
                read_en1  <= 1'b1;
                state_q   <= StRd1;
              end
              StRd1: begin
                read_en1  <= 1'b0;
                write_en2 <= 1'b1;
                state_q   <= StWr2;
              end
              StWr2: begin
                write_en2 <= 1'b0;
                read_en2  <= 1'b1;
                state_q   <= StRd2;
              end
              StRd2: begin
                read_en2    <= 1'b0;
                write_en    <= 1'b1;
                reset_value <= 1'b0;
                state_q     <= StWrn;
              end
              StWrn: begin
                write_en <= 1'b0;
                read_en  <= 1'b1;
                state_q  <= StRdn;
              end
              StRdn: begin
                read_en <= 1'b0;
                pat_q   <= pat_nxt;
                x_input <= pat_nxt[0];
                y_input <= pat_nxt[1];
                state_q <= StSettle;
                if (pat_q == 2'd3) begin
                  epoch_count <= epoch_count + EPOCH_W'(1);
                  if (last_epoch) begin
                    TestFlag <= 1'b1;
                    state_q  <= StTest;
                  end
                end
              end
              StTest: begin
                // Score on the last hold cycle so the network has settled.
                if (hit && test_correct != 3'd4) begin
                  test_correct <= test_correct + 3'd1;
                end
                pat_q <= pat_nxt;
                if (pat_q == 2'd3) begin
                  test_pass <= ((test_correct + {2'b00, hit}) == 3'd4);
                  TestFlag  <= 1'b0;
                  x_input   <= 1'b0;
                  y_input   <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_q   <= StDone;
                end else begin
                  x_input <= pat_nxt[0];
                  y_input <= pat_nxt[1];
                end
              end
              default: state_q <= StIdle;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_training_sequencer.sv
module tb_nn_training_sequencer;

  localparam int PH = 2;
  localparam int ST = 4;
  localparam int EP = 2;
  localparam int TH = 3;
  localparam int EW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic mode = 1'b0;  // 0: ideal network, 1: predicted stuck at 00

  logic x, y, we, re, we1, re1, we2, re2, rv, tf, busy, done, tp;
  logic [EW-1:0] ep;
  logic [2:0] tc;
  logic [1:0] pred;

  logic x0, y0, we0, re0, we10, re10, we20, re20, rv0, tf0, busy0, done0, tp0;
  logic [EW-1:0] ep0;
  logic [2:0] tc0;
  logic [1:0] pred0;

  assign pred  = mode ? 2'b00 : {1'b0, x ^ y};
  assign pred0 = {1'b0, x0 ^ y0};

  always #5 clk = ~clk;

  nn_training_sequencer #(
    .PHASE_CYC(PH), .SETTLE_CYC(ST), .EPOCHS(EP), .EPOCH_W(EW), .TEST_HOLD(TH)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .predicted(pred),
    .x_input(x), .y_input(y), .write_en(we), .read_en(re),
    .write_en1(we1), .read_en1(re1), .write_en2(we2), .read_en2(re2),
    .reset_value(rv), .TestFlag(tf), .busy(busy), .done(done),
    .epoch_count(ep), .test_correct(tc), .test_pass(tp)
  );

  nn_training_sequencer #(
    .PHASE_CYC(PH), .SETTLE_CYC(ST), .EPOCHS(0), .EPOCH_W(EW), .TEST_HOLD(TH)
  ) dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .predicted(pred0),
    .x_input(x0), .y_input(y0), .write_en(we0), .read_en(re0),
    .write_en1(we10), .read_en1(re10), .write_en2(we20), .read_en2(re20),
    .reset_value(rv0), .TestFlag(tf0), .busy(busy0), .done(done0),
    .epoch_count(ep0), .test_correct(tc0), .test_pass(tp0)
  );

  typedef struct {
    logic [5:0] en;
    logic       x;
    logic       y;
    logic       rv;
    logic       tf;
    int         len;
  } run_t;

  typedef struct {
    int   ep;
    int   tc;
    logic tp;
    int   blen;
  } res_t;

  run_t exp_runs[$];
  res_t exp_res[$];
  res_t exp_res0[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_run(input logic [5:0] en, input logic xx, input logic yy,
                          input logic r, input logic t, input int len);
    run_t item;
    item.en = en; item.x = xx; item.y = yy; item.rv = r; item.tf = t; item.len = len;
    exp_runs.push_back(item);
  endtask

  // Enable encoding {write_en, read_en, write_en1, read_en1, write_en2, read_en2}.
  task automatic push_training();
    logic first;
    logic [1:0] pb;
    push_run(6'b100000, 1'b0, 1'b0, 1'b1, 1'b0, PH);
    push_run(6'b010000, 1'b0, 1'b0, 1'b1, 1'b0, PH);
    for (int e = 0; e < EP; e++) begin
      for (int p = 0; p < 4; p++) begin
        pb = 2'(p);
        first = (e == 0 && p == 0);
        push_run(6'b000000, pb[0], pb[1], first, 1'b0, ST);
        push_run(6'b001000, pb[0], pb[1], first, 1'b0, PH);
        push_run(6'b000100, pb[0], pb[1], first, 1'b0, PH);
        push_run(6'b000010, pb[0], pb[1], first, 1'b0, PH);
        push_run(6'b000001, pb[0], pb[1], first, 1'b0, PH);
        push_run(6'b100000, pb[0], pb[1], 1'b0, 1'b0, PH);
        push_run(6'b010000, pb[0], pb[1], 1'b0, 1'b0, PH);
      end
    end
    for (int p = 0; p < 4; p++) begin
      pb = 2'(p);
      push_run(6'b000000, pb[0], pb[1], 1'b0, 1'b1, TH);
    end
  endtask

  task automatic close_run(input logic [9:0] s, input int len);
    run_t e;
    n_checks++;
    if (exp_runs.size() == 0) begin
      n_fail++;
      $display("FAIL run: unexpected en=%b x=%b y=%b rv=%b tf=%b len=%0d",
               s[9:4], s[3], s[2], s[1], s[0], len);
    end else begin
      e = exp_runs.pop_front();
      if (s !== {e.en, e.x, e.y, e.rv, e.tf} || len != e.len) begin
        n_fail++;
        $display("FAIL run: got en=%b x=%b y=%b rv=%b tf=%b len=%0d, expected en=%b x=%b y=%b rv=%b tf=%b len=%0d",
                 s[9:4], s[3], s[2], s[1], s[0], len, e.en, e.x, e.y, e.rv, e.tf, e.len);
      end
    end
  endtask

  // Monitor: collapses each cycle's outputs into runs and checks them in order.
  logic [5:0] en;
  logic [9:0] sig;
  assign en  = {we, re, we1, re1, we2, re2};
  assign sig = {en, x, y, rv, tf};

  logic       in_run = 1'b0;
  logic [9:0] cur;
  int         cur_len = 0;
  int         bcnt = 0;

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      in_run = 1'b0;
      bcnt = 0;
    end else begin
      check("enables one-hot", 32'($onehot0(en)), 32'd1);
      if (busy) begin
        bcnt++;
        if (!in_run) begin
          in_run = 1'b1; cur = sig; cur_len = 1;
        end else if (sig == cur) begin
          cur_len++;
        end else begin
          close_run(cur, cur_len);
          cur = sig; cur_len = 1;
        end
      end else if (in_run) begin
        close_run(cur, cur_len);
        in_run = 1'b0;
      end
      if (done) begin
        check("idle outputs on done", 32'({en, x, y, tf, busy}), 32'd0);
        n_checks++;
        if (exp_res.size() == 0) begin
          n_fail++;
          $display("FAIL done: unexpected done pulse, got 1, expected 0");
        end else begin
          r = exp_res.pop_front();
          check("epoch_count", 32'(ep), 32'(r.ep));
          check("test_correct", 32'(tc), 32'(r.tc));
          check("test_pass", 32'(tp), 32'(r.tp));
          check("busy cycles", 32'(bcnt), 32'(r.blen));
        end
        bcnt = 0;
      end
    end
  end

  int   bcnt0 = 0;
  logic wr1_seen0 = 1'b0;

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      bcnt0 = 0;
    end else begin
      if (busy0) bcnt0++;
      if (we10 || re10 || we20 || re20) wr1_seen0 = 1'b1;
      if (done0) begin
        n_checks++;
        if (exp_res0.size() == 0) begin
          n_fail++;
          $display("FAIL done0: unexpected done pulse, got 1, expected 0");
        end else begin
          r = exp_res0.pop_front();
          check("e0 epoch_count", 32'(ep0), 32'(r.ep));
          check("e0 test_correct", 32'(tc0), 32'(r.tc));
          check("e0 test_pass", 32'(tp0), 32'(r.tp));
          check("e0 busy cycles", 32'(bcnt0), 32'(r.blen));
          check("e0 update phases seen", 32'(wr1_seen0), 32'd0);
        end
        bcnt0 = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " enables"}, 32'({we, re, we1, re1, we2, re2}), 32'd0);
    check({tag, " x/y/TestFlag"}, 32'({x, y, tf}), 32'd0);
    check({tag, " busy/done"}, 32'({busy, done}), 32'd0);
    check({tag, " counters"}, 32'({ep, tc, tp}), 32'd0);
    check({tag, " reset_value"}, 32'(rv), 32'd1);
  endtask

  task automatic run_full(input logic m, input int exp_tc, input logic exp_tp);
    res_t r;
    mode = m;
    push_training();
    r.ep = EP; r.tc = exp_tc; r.tp = exp_tp; r.blen = 144;
    exp_res.push_back(r);
    pulse_start();
    // Requests while busy must be ignored.
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (80) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    check("done within bound", 32'(done), 32'd1);
    // Request on the done cycle must be ignored too.
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check("start on done ignored", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("epoch_count held", 32'(ep), 32'(EP));
    check("test_correct held", 32'(tc), 32'(exp_tc));
    check("test_pass held", 32'(tp), 32'(exp_tp));
    check("runs consumed", 32'(exp_runs.size()), 32'd0);
  endtask

  initial begin
    res_t r;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    run_full(1'b0, 4, 1'b1);
    run_full(1'b1, 2, 1'b0);

    // Reset in the middle of the test pass.
    mode = 1'b0;
    push_training();
    pulse_start();
    for (int i = 0; i < 400 && !tf; i++) @(negedge clk);
    check("reached test pass", 32'(tf), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    start = 1'b1;
    #2 check_reset_outputs("start under reset");
    exp_runs.delete();
    exp_res.delete();
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle after reset", 32'(busy), 32'd0);

    // EPOCHS = 0: initial load then straight into the test pass.
    r.ep = 0; r.tc = 4; r.tp = 1'b1; r.blen = 16;
    exp_res0.push_back(r);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 100 && !done0; i++) @(negedge clk);
    check("e0 done within bound", 32'(done0), 32'd1);
    repeat (3) @(negedge clk);
    check("e0 results consumed", 32'(exp_res0.size()), 32'd0);
    check("results consumed", 32'(exp_res.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
